// File: rtl/transpose_pkg.sv
// Shared types for the streaming transpose controller.
package transpose_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/reverse_dimensions.sv
// Combinational transpose of a flat D1 x D2 bit matrix: in[i*D2+j] -> out[j*D1+i].
module reverse_dimensions #(
  parameter int D1_WIDTH = 2,
  parameter int D2_WIDTH = 8
) (
  input  logic [D1_WIDTH*D2_WIDTH-1:0] i_data,
  output logic [D1_WIDTH*D2_WIDTH-1:0] o_data
);

  for (genvar i = 0; i < D1_WIDTH; i++) begin : g_d1
    for (genvar j = 0; j < D2_WIDTH; j++) begin : g_d2
      assign o_data[j*D1_WIDTH+i] = i_data[i*D2_WIDTH+j];
    end
  end

endmodule

// File: rtl/transpose_sequencer.sv
// Streaming matrix transpose: fills a ROWS x COLS buffer one row per handshake,
// then drains it one column per handshake.
module transpose_sequencer
  import transpose_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 8,
  parameter int ELEM_W = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COLS*ELEM_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROWS*ELEM_W-1:0]   out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_e                              r_state, w_state_nxt;
  logic [ROW_W-1:0]                    r_row_cnt, w_row_nxt;
  logic [COL_W-1:0]                    r_col_cnt, w_col_nxt;
  logic                                w_row_we;
  logic [ROWS-1:0][COLS-1:0][ELEM_W-1:0] r_buf;
  logic [COLS-1:0][ROWS-1:0][ELEM_W-1:0] w_tr;

  // Single-bit elements reuse the flat transpose; wider elements regroup whole elements.
  if (ELEM_W == 1) begin : g_rd
    logic [ROWS*COLS-1:0] w_rd_out;
    reverse_dimensions #(
      .D1_WIDTH(ROWS),
      .D2_WIDTH(COLS)
    ) u_reverse_dimensions (
      .i_data(r_buf),
      .o_data(w_rd_out)
    );
    assign w_tr = w_rd_out;
  end else begin : g_elem
    for (genvar r = 0; r < ROWS; r++) begin : g_r
      for (genvar c = 0; c < COLS; c++) begin : g_c
        assign w_tr[c][r] = r_buf[r][c];
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_FILL;
      r_row_cnt <= '0;
      r_col_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_nxt;
      r_col_cnt <= w_col_nxt;
    end
  end

  // Row buffer; a row is only written on a non-aborted fill handshake.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_buf <= '0;
    end else if (w_row_we) begin
      r_buf[r_row_cnt] <= in_data;
    end
  end

  // Next-state logic; abort overrides any handshake in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_cnt;
    w_col_nxt   = r_col_cnt;
    w_row_we    = 1'b0;
    if (abort) begin
      w_state_nxt = ST_FILL;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (in_valid) begin
            w_row_we = 1'b1;
            if (r_row_cnt == ROW_LAST) begin
              w_row_nxt   = '0;
              w_state_nxt = ST_DRAIN;
            end else begin
              w_row_nxt = r_row_cnt + ROW_W'(1);
            end
          end else begin
            w_row_nxt = r_row_cnt;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_col_cnt == COL_LAST) begin
              w_col_nxt   = '0;
              w_state_nxt = ST_FILL;
            end else begin
              w_col_nxt = r_col_cnt + COL_W'(1);
            end
          end else begin
            w_col_nxt = r_col_cnt;
          end
        end
        default: begin
          w_state_nxt = ST_FILL;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_FILL);
  assign out_valid = (r_state == ST_DRAIN);
  assign out_last  = (r_state == ST_DRAIN) && (r_col_cnt == COL_LAST);
  assign out_data  = (r_state == ST_DRAIN) ? w_tr[r_col_cnt] : '0;
  assign busy      = (r_row_cnt != '0) || (r_state == ST_DRAIN);

endmodule
